// File: rtl/md_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : md_seq
//  Purpose  : Iterative radix-2 multiply/divide sequencer for the EX stage.
//             Accepts mult/multu/div/divu, runs one iteration per cycle for
//             WIDTH cycles, stalls EX while running, and presents a
//             registered HI/LO result for a single cycle.
//  Ports    : clk, rst (async, active-high)
//             start, op[1:0], src_a, src_b, cancel    -- request from EX
//             stallreq_for_ex (comb), busy, result_valid (registered)
//             hi_o, lo_o                              -- HI/LO result
//  Revision : 1.0  initial release
// ============================================================================
module md_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             stallreq_for_ex,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int              CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 div_q, div_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic [WIDTH-1:0]     raw_a_q, raw_a_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic                 busy_q, busy_d;
  logic                 result_valid_q, result_valid_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Operand conditioning at acceptance: signed ops keep magnitudes plus signs.
  logic                 in_signed, in_neg_a, in_neg_b;
  logic [WIDTH-1:0]     in_abs_a, in_abs_b;

  // One engine step of each kind.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     rem_next, quo_next;

  // Final results after sign fixup.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    in_signed = ~op[0];
    in_neg_a  = in_signed & src_a[WIDTH-1];
    in_neg_b  = in_signed & src_b[WIDTH-1];
    // The most negative value negates to itself, which is its correct
    // unsigned magnitude.
    in_abs_a  = in_neg_a ? -src_a : src_a;
    in_abs_b  = in_neg_b ? -src_b : src_b;
  end

  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit (LSB of the accumulator) is set, then shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring division: the dividend bits stream out of quo_q's MSB while
    // quotient bits stream in at the LSB.
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    div_ge    = ~div_diff[WIDTH];
    rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], div_ge};

    prod_fix  = (sign_a_q ^ sign_b_q) ? -mul_next : mul_next;
    quo_fix   = (sign_a_q ^ sign_b_q) ? -quo_next : quo_next;
    rem_fix   = sign_a_q ? -rem_next : rem_next;
    // Zero divisor: quotient all ones, remainder is the dividend as issued.
    if (mag_b_q == '0) begin
      quo_fix = '1;
      rem_fix = raw_a_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    raw_a_d  = raw_a_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && !cancel) begin
          state_d  = S_RUN;
          div_d    = op[1];
          sign_a_d = in_neg_a;
          sign_b_d = in_neg_b;
          mag_a_d  = in_abs_a;
          mag_b_d  = in_abs_b;
          raw_a_d  = src_a;
          acc_d    = {{WIDTH{1'b0}}, in_abs_b};
          rem_d    = '0;
          quo_d    = in_abs_a;
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (div_q) begin
            rem_d = rem_next;
            quo_d = quo_next;
          end else begin
            acc_d = mul_next;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_DONE;
            cnt_d   = '0;
            hi_d    = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_d    = div_q ? quo_fix : prod_fix[WIDTH-1:0];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d         = (state_d == S_RUN);
    result_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      div_q          <= 1'b0;
      sign_a_q       <= 1'b0;
      sign_b_q       <= 1'b0;
      mag_a_q        <= '0;
      mag_b_q        <= '0;
      raw_a_q        <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      sign_a_q       <= sign_a_d;
      sign_b_q       <= sign_b_d;
      mag_a_q        <= mag_a_d;
      mag_b_q        <= mag_b_d;
      raw_a_q        <= raw_a_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
    end
  end

  assign stallreq_for_ex = ((state_q == S_IDLE) && start && !cancel) || (state_q == S_RUN);
  assign busy            = busy_q;
  assign result_valid    = result_valid_q;
  assign hi_o            = hi_q;
  assign lo_o            = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_md_seq
//  Purpose  : Self-checking bench for md_seq: timeline/arithmetic reference
//             model compared every cycle, directed literal cases, randomized
//             operations with random cancels.
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         stallreq_for_ex, busy, result_valid;
  logic [W-1:0] hi_o, lo_o;

  md_seq #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .src_a           (src_a),
    .src_b           (src_b),
    .cancel          (cancel),
    .stallreq_for_ex (stallreq_for_ex),
    .busy            (busy),
    .result_valid    (result_valid),
    .hi_o            (hi_o),
    .lo_o            (lo_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Arithmetic definition of each operation, {hi, lo}.
  function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Timeline model: age counts cycles since the acceptance cycle.
  bit          m_active = 1'b0;
  int          m_age    = 0;
  logic [63:0] m_res    = '0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_hi     <= '0;
      m_lo     <= '0;
    end else if (!m_active) begin
      if (start && !cancel) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_res    <= ref_calc(op, src_a, src_b);
      end
    end else if (m_age <= 32 && cancel) begin
      m_active <= 1'b0;
    end else if (m_age == 33) begin
      m_active <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (m_age == 32) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end
  end

  bit e_busy, e_valid, e_stall;
  always @(negedge clk) begin
    e_busy  = m_active && (m_age <= 32);
    e_valid = m_active && (m_age == 33);
    e_stall = (!m_active && start && !cancel) || e_busy;
    check("busy", 64'(busy), 64'(e_busy));
    check("result_valid", 64'(result_valid), 64'(e_valid));
    check("stallreq", 64'(stallreq_for_ex), 64'(e_stall));
    check("hi_o", 64'(hi_o), 64'(m_hi));
    check("lo_o", 64'(lo_o), 64'(m_lo));
  end

  // Issue one op, holding start while stalled. lat = cycle index of
  // result_valid relative to acceptance, or -1 if none (cancel or timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, output int lat);
    lat = -1;
    @(posedge clk); #2;
    start = 1'b1; op = o; src_a = a; src_b = b; cancel = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #2;
      if (cancel) begin
        cancel = 1'b0;
        start  = 1'b0;
        return;
      end
      if (k + 1 == cancel_at) cancel = 1'b1;
    end
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic do_dir(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int lat;
    run_op(o, a, b, 0, lat);
    check({name, "_latency"}, 64'(lat), 64'd33);
    check(name, {hi_o, lo_o}, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int lat, ca;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(result_valid), 64'd0);
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    do_dir("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    check("multu_valid_drop", 64'(result_valid), 64'd0);
    do_dir("mult_m3x7",  2'b00, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB);
    do_dir("mult_min2",  2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_dir("div_m7d2",   2'b10, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD);
    do_dir("divu_100d7", 2'b11, 32'd100,       32'd7,        64'h0000_0002_0000_000E);
    do_dir("divu_7d0",   2'b11, 32'd7,         32'd0,        64'h0000_0007_FFFF_FFFF);
    do_dir("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    // Cancel in RUN cycle 10 after a completed divu 100/7.
    do_dir("divu_pre_cancel", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    run_op(2'b00, 32'd5, 32'd6, 10, lat);
    check("cancel_no_valid", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("cancel_stall", 64'(stallreq_for_ex), 64'd0);
    check("cancel_hilo_hold", {hi_o, lo_o}, 64'h0000_0002_0000_000E);

    // start together with cancel is not accepted.
    @(posedge clk); #2;
    start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    check("start_cancel_stall", 64'(stallreq_for_ex), 64'd0);
    @(posedge clk); #2;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("start_cancel_busy", 64'(busy), 64'd0);

    // Asynchronous reset in RUN cycle 20.
    @(posedge clk); #2;
    start = 1'b1; op = 2'b01; src_a = 32'd123; src_b = 32'd456;
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_busy", 64'(busy), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_valid", 64'(result_valid), 64'd0);
    check("async_rst_hilo", {hi_o, lo_o}, 64'd0);
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    do_dir("multu_3x5", 2'b01, 32'd3, 32'd5, 64'd15);

    // Randomized operations, some cancelled mid-run.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      ca = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 32)) : 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op(ro, ra, rb, ca, lat);
      if (ca == 0) begin
        check("rand_latency", 64'(lat), 64'd33);
        check("rand_result", {hi_o, lo_o}, ref_calc(ro, ra, rb));
      end else begin
        check("rand_cancel_no_valid", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_seq.md
# md_seq

Iterative multiply/divide sequencer for the EX stage of the 5-stage pipeline. It accepts a mult/multu/div/divu request from EX and runs a 32-iteration radix-2 shift-add or shift-subtract engine. While the engine runs it holds the pipeline through `stallreq_for_ex`, which the pipeline controller turns into an EX-and-earlier stall. On completion it presents a registered 64-bit HI/LO result for one cycle so the HI/LO register file can capture it.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  EX holds a valid mult/div instruction; a level, held high while EX is stalled.
- `op`  in  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- `src_a`  in  WIDTH  multiplicand or dividend (rs).
- `src_b`  in  WIDTH  multiplier or divisor (rt).
- `cancel`  in  1  flush; aborts an in-flight or requested operation.
- `stallreq_for_ex`  out  1  combinational stall request to the pipeline controller.
- `busy`  out  1  registered; high in RUN.
- `result_valid`  out  1  registered; one-cycle pulse in DONE.
- `hi_o`  out  WIDTH  product[63:32] or remainder.
- `lo_o`  out  WIDTH  product[31:0] or quotient.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Output reset values: `busy`=0, `result_valid`=0, `hi_o`=0, `lo_o`=0, iteration counter=0.
- IDLE:
  - When `start`=1 and `cancel`=0, latch `op` and the operands and go to RUN.
  - For signed ops, latch the absolute values plus the two sign bits.
  - Counter is cleared.
- RUN:
  - One iteration per cycle; the counter increments from 0 to WIDTH-1.
  - Multiply uses a shift-add into a 2*WIDTH accumulator.
  - Divide uses a restoring shift-subtract with a WIDTH+1-bit partial remainder.
  - After iteration WIDTH-1, apply sign fixup and go to DONE.
- Sign fixup:
  - Signed product is negated when `sign_a` XOR `sign_b`.
  - Signed quotient is negated when `sign_a` XOR `sign_b`.
  - Signed remainder takes the sign of the dividend.
- DONE:
  - `result_valid`=1 and `hi_o`/`lo_o` carry the final result.
  - Unconditionally return to IDLE next cycle.
- `hi_o`/`lo_o` are written only on entry to DONE and hold their value until the next completion.
- `stallreq_for_ex` = (IDLE & `start` & ~`cancel`) | RUN. It is 0 in DONE, so the instruction leaves EX in the same cycle its result is valid.
- Divide by zero (both div and divu): `lo_o`=all ones, `hi_o`=`src_a` as latched (raw, not the absolute value). The engine still takes the full 32 cycles.
- Signed overflow 0x8000_0000 / -1: `lo_o`=0x8000_0000, `hi_o`=0. This falls out of magnitude arithmetic with no special case.
- `cancel`:
  - In IDLE, `cancel` has priority over `start`; nothing is accepted.
  - In RUN, go to IDLE at the next edge; no `result_valid`, and `hi_o`/`lo_o` are unchanged.
  - In DONE, `cancel` is ignored.
- `start` is not sampled in RUN or DONE. A `start` still high in the cycle after DONE is treated as a new request.

## Timing
- Cycle 0 (acceptance): IDLE with `start`=1; `stallreq_for_ex`=1 combinationally.
- Cycles 1..32: RUN; `busy`=1 and `stallreq_for_ex`=1.
- Cycle 33: DONE; `result_valid`=1, `stallreq_for_ex`=0.
- Total: 33 stall cycles and a latency of 33 cycles from acceptance to `result_valid`.
- Back-to-back operations: the earliest next acceptance is cycle 34, giving a throughput of one op per 34 cycles.
- Cancel: asserted in RUN cycle k, the block is IDLE at cycle k+1 and `stallreq_for_ex` drops at cycle k+1.
- Async reset: at any point, all outputs go to their reset values immediately and the FSM goes to IDLE. The first acceptance is possible on the first edge after `rst` deasserts.

## Test plan
- multu 0xFFFF_FFFF × 0xFFFF_FFFF: `stallreq_for_ex` high cycles 0–32; at cycle 33, `result_valid`=1, `hi_o`=0xFFFF_FFFE, `lo_o`=0x0000_0001; `result_valid`=0 at cycle 34.
- mult -3 × 7: `hi_o`=0xFFFF_FFFF, `lo_o`=0xFFFF_FFEB. mult 0x8000_0000 × 0x8000_0000: `hi_o`=0x4000_0000, `lo_o`=0.
- div -7 / 2: `lo_o`=0xFFFF_FFFD, `hi_o`=0xFFFF_FFFF. divu 100 / 7: `lo_o`=14, `hi_o`=2.
- divu 7 / 0: `lo_o`=0xFFFF_FFFF, `hi_o`=7. div 0x8000_0000 / 0xFFFF_FFFF: `lo_o`=0x8000_0000, `hi_o`=0.
- Complete divu 100/7, then start mult and pulse `cancel` in RUN cycle 10: `stallreq_for_ex`=0 from cycle 11, no `result_valid`, and `hi_o`/`lo_o` stay at 2/14. Then `start` with `cancel` asserted in the same cycle: the request is not accepted and `stallreq_for_ex`=0.
- Assert `rst` in RUN cycle 20: outputs are immediately 0 and the FSM is IDLE. After `rst` deasserts, a new multu 3×5 gives `hi_o`=0, `lo_o`=15 at cycle 33.
